// File: rtl/dtim_mem_resp.sv
// dtim_mem_resp: word-addressed data memory responder with wait states.
// Optional DTIM_MEM_RESP_BOUND_EN drops accesses outside the window.

package dtim_mem_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

endpackage

module dtim_mem_resp
  import dtim_mem_pkg::*;
#(
  parameter int          mem_depth   = 12,
  parameter int unsigned mem_latency = 2,
  parameter logic [31:0] mem_base    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out
);

  localparam int         Words = 1 << mem_depth;
  localparam logic [3:0] Lat   = 4'(mem_latency);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt, cnt_nxt;
  logic        cap, acc;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        fence_q;
  logic [31:0] rdata_q;

  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_fence;
  logic [31:0] off;
  logic [mem_depth-1:0] idx;
  logic        in_win, is_load, is_store;
  logic        unused_bits;

  logic [31:0] mem [Words] = '{default: '0};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (dmem_in.mem_valid) begin
          cap       = 1'b1;
          cnt_nxt   = Lat;
          state_nxt = (Lat == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    acc = (state_nxt == RESP) && (state != RESP);
  end

  // Zero-latency requests are served straight from the port.
  always_comb begin
    req_addr  = addr_q;
    req_wdata = wdata_q;
    req_wstrb = wstrb_q;
    req_fence = fence_q;
    if (state == IDLE) begin
      req_addr  = dmem_in.mem_addr;
      req_wdata = dmem_in.mem_wdata;
      req_wstrb = dmem_in.mem_wstrb;
      req_fence = dmem_in.mem_fence;
    end
  end

  assign off      = req_addr - mem_base;
  assign idx      = off[mem_depth+1:2];
  assign is_store = !req_fence && (req_wstrb != 4'h0);
  assign is_load  = !req_fence && (req_wstrb == 4'h0);

`ifdef DTIM_MEM_RESP_BOUND_EN
  assign in_win = (req_addr >= mem_base) &&
                  (off[31:mem_depth+2] == '0);
`else
  assign in_win = 1'b1;
`endif

  assign unused_bits = ^{dmem_in.mem_instr, off[1:0],
                         off[31:mem_depth+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      fence_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cap) begin
        addr_q  <= dmem_in.mem_addr;
        wdata_q <= dmem_in.mem_wdata;
        wstrb_q <= dmem_in.mem_wstrb;
        fence_q <= dmem_in.mem_fence;
      end
      if (acc) begin
        rdata_q <= (is_load && in_win) ? mem[idx] : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && acc && is_store && in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign dmem_out = '{mem_rdata: rdata_q,
                      mem_ready: (state == RESP)};

endmodule

// File: tb/tb_dtim_mem_resp.sv
// tb_dtim_mem_resp: directed scoreboard bench for dtim_mem_resp.
// Unit 0 uses a 4K-word array, unit 1 a 16-word array for window tests.

module tb_dtim_mem_resp;
  import dtim_mem_pkg::*;

  localparam int LAT = 2;

`ifdef DTIM_MEM_RESP_BOUND_EN
  localparam bit BND = 1'b1;
`else
  localparam bit BND = 1'b0;
`endif

  typedef struct {
    int          unit;
    logic [31:0] data;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  mem_in_type  din0 = '0;
  mem_in_type  din1 = '0;
  mem_out_type dout0, dout1;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  dtim_mem_resp #(
    .mem_depth(12),
    .mem_latency(LAT),
    .mem_base(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dmem_in(din0),
    .dmem_out(dout0)
  );

  dtim_mem_resp #(
    .mem_depth(4),
    .mem_latency(LAT),
    .mem_base(32'h0)
  ) dut_s (
    .clk(clk),
    .rst(rst),
    .dmem_in(din1),
    .dmem_out(dout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resp(int u, logic [31:0] rd);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL spurious_ready: unit %0d rdata %h, expected none",
             u, rd);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("resp_unit", 32'(u), 32'(e.unit));
      chk("resp_rdata", rd, e.data);
      chk("resp_cycle", 32'(cyc), 32'(e.at));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dout0.mem_ready) resp(0, dout0.mem_rdata);
      if (dout1.mem_ready) resp(1, dout1.mem_rdata);
    end
  end

  task automatic set_in(int u, logic v, logic [31:0] a,
                        logic [31:0] d, logic [3:0] s, logic f);
    mem_in_type m;
    m = '{mem_valid: v, mem_fence: f, mem_instr: 1'b0,
          mem_addr: a, mem_wdata: d, mem_wstrb: s};
    if (u == 0) din0 = m;
    else din1 = m;
  endtask

  task automatic xfer(int u, logic [31:0] a, logic [31:0] d,
                      logic [3:0] s, logic f, logic [31:0] exp);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    set_in(u, 1'b1, a, d, s, f);
    sb.push_back('{u, exp, cyc + 1 + LAT});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (u == 0) ? dout0.mem_ready : dout1.mem_ready;
    end
    chk("ready_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    set_in(u, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  logic [31:0] words [4];
  int          start;
  int          n;

  initial begin
    words[0] = 32'hA0A0A0A0;
    words[1] = 32'hB1B1B1B1;
    words[2] = 32'hC2C2C2C2;
    words[3] = 32'hD3D3D3D3;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", 32'(dout0.mem_ready), 32'h0);
      chk("idle_rdata", dout0.mem_rdata, 32'h0);
    end

    xfer(0, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    xfer(0, 32'h40, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

    xfer(0, 32'h44, 32'h11223344, 4'hF, 1'b0, 32'h0);
    xfer(0, 32'h44, 32'h000000AA, 4'h1, 1'b0, 32'h0);
    xfer(0, 32'h44, 32'h0, 4'h0, 1'b0, 32'h112233AA);
    xfer(0, 32'h46, 32'h0000BB00, 4'h2, 1'b0, 32'h0);
    xfer(0, 32'h44, 32'h0, 4'h0, 1'b0, 32'h1122BBAA);
    xfer(0, 32'h44, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    xfer(0, 32'h44, 32'h0, 4'h0, 1'b0, 32'h1122BBAA);

    for (int i = 0; i < 4; i++)
      xfer(0, 32'h100 + 32'(4 * i), words[i], 4'hF, 1'b0, 32'h0);
    @(posedge clk); #1;
    set_in(0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
    start = cyc;
    for (int i = 0; i < 4; i++)
      sb.push_back('{0, words[i], start + 1 + LAT + i * (LAT + 2)});
    n = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      if (dout0.mem_ready) begin
        n++;
        din0.mem_addr = din0.mem_addr + 32'h4;
        if (n == 4) din0.mem_valid = 1'b0;
      end
    end
    chk("burst_count", 32'(n), 32'h4);

    xfer(0, 32'h80, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    @(posedge clk); #1;
    set_in(0, 1'b1, 32'h80, 32'h12345678, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_ready", 32'(dout0.mem_ready), 32'h0);
    end
    xfer(0, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);

    @(posedge clk); #1;
    rst = 1'b1;
    set_in(0, 1'b1, 32'h80, 32'h55555555, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("rst_valid_no_ready", 32'(dout0.mem_ready), 32'h0);
    end
    xfer(0, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);

    xfer(1, 32'h0, 32'hCAFE0000, 4'hF, 1'b0, 32'h0);
    xfer(1, 32'h40, 32'h0, 4'h0, 1'b0, BND ? 32'h0 : 32'hCAFE0000);
    xfer(1, 32'h40, 32'h5555AAAA, 4'hF, 1'b0, 32'h0);
    xfer(1, 32'h0, 32'h0, 4'h0, 1'b0,
         BND ? 32'hCAFE0000 : 32'h5555AAAA);

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dtim_mem_resp.md
# dtim_mem_resp

Single-port word-addressed memory responder that serves the `mem_in_type`/`mem_out_type` request interface driven by the data TIM controller on its `dmem_in`/`dmem_out` side. It accepts one request at a time (load, store, or fence), inserts a programmable number of wait states, and returns a one-cycle `mem_ready` pulse with read data. It sits below `dtim` in simulation and FPGA builds as the backing data memory, and also serves as the reference responder for controller verification.

## Interface
- `mem_depth`, 12, log2 of the number of 32-bit words stored.
- `mem_latency`, 2, wait states between acceptance and response; legal range 0..15.
- `mem_base`, 32'h0, byte address of word 0.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `dmem_in`  input  mem_in_type  request: `mem_valid`, `mem_fence`, `mem_instr` (ignored), `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`.
- `dmem_out`  output  mem_out_type  response: `mem_rdata[31:0]`, `mem_ready`.

## Operation
- States: IDLE, WAIT, RESP. Reset: state IDLE, counter 0, `mem_ready`=0, `mem_rdata`=0. Array contents are not cleared by reset; initialised to zero at time 0.
- IDLE: if `mem_valid`=1, capture addr, wdata, wstrb, fence into request registers; counter := `mem_latency`. If `mem_latency`=0, go directly to RESP, otherwise go to WAIT. If `mem_valid`=0, stay in IDLE.
- WAIT: counter decrements each cycle; when counter reaches 1, go to RESP. `dmem_in` is ignored for the entire WAIT period; the initiator holds its request stable.
- Transition into RESP (single edge) performs the access:
  - Load (`wstrb`=0, fence=0): `mem_rdata` := array[index].
  - Store (`wstrb`≠0): bytes with `wstrb[i]`=1 are written at [8i+7:8i]; other bytes are preserved. `mem_rdata` := 0.
  - Fence: no array access; `mem_rdata` := 0.
- Index = (captured addr − `mem_base`)[mem_depth+1:2]. Address bits [1:0] are ignored.
- RESP: `mem_ready`=1 for exactly one cycle, then IDLE. `dmem_in` is ignored during RESP, because the initiator may change `mem_addr` combinationally in the ready cycle. A request still asserted in the following IDLE cycle is accepted there as a new request.
- `mem_rdata` holds its last value outside RESP. Initiators must qualify it with `mem_ready`.

## Timing
- Request accepted at edge T (IDLE with `mem_valid`=1) → `mem_ready` high during cycle T+1+`mem_latency`.
- Back-to-back throughput: one request per `mem_latency`+2 cycles.
- Store data is visible to a load accepted in the IDLE cycle immediately after RESP.
- `rst` high at any edge, including mid-WAIT: pending request is dropped, no array write, no `mem_ready` pulse. A request still asserted after `rst` falls is accepted afresh.
- `rst` and `mem_valid` high on the same edge: reset wins, and the request is not captured.

## Configuration
- `DTIM_MEM_RESP_BOUND_EN` defined:
  - Out-of-window addresses (addr < `mem_base` or addr ≥ `mem_base` + 4·2^`mem_depth`) still complete with normal latency.
  - Stores to such addresses are dropped; loads return 32'h0.
- Not defined: no bounds check. The index wraps modulo 2^`mem_depth`, so out-of-window accesses alias into the array.

## Test plan
- Reset then idle, `mem_latency`=2: `mem_ready`=0 and `mem_rdata`=0 for 10 cycles.
- Store 32'hDEADBEEF to 0x40 with `wstrb`=4'hF, then load 0x40:
  - store's `mem_ready` arrives 3 cycles after acceptance, with `mem_rdata`=0;
  - load returns 32'hDEADBEEF, `mem_ready` 3 cycles after its acceptance.
- Partial store of 32'h000000AA with `wstrb`=4'h1 over 32'h11223344: subsequent load returns 32'h112233AA.
- Four-word burst with `mem_valid` held high and address stepping by 4 on each `mem_ready`: exactly four ready pulses, spaced 4 cycles apart, returning the correct words in order. The stepped address shown during the RESP cycle is not captured.
- Assert `rst` for one cycle during WAIT of a store to 0x80: no ready pulse; a later load of 0x80 returns the prior value.
- With `DTIM_MEM_RESP_BOUND_EN` and `mem_depth`=4: load at `mem_base`+0x40 returns 0, and a store there leaves word 0 unchanged. Without the macro, the same store overwrites word 0.
